// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, IR and next-PC
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm
);

  typedef enum logic [1:0] {BOOT, REQ, EXEC} state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] next_pc;

  assign imem_addr = pc;
  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm       = ir[15:0];

  // Branch offset is the word-scaled, sign-extended immediate; wraps silently.
  assign seq_pc  = pc + ADDR_W'(4);
  assign br_off  = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
  assign next_pc = branch_taken ? (seq_pc + br_off) : seq_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
      ir          <= 32'h0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          // A stall freezes the window; branch_taken only counts on release.
          if (!stall) begin
            pc          <= next_pc;
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        instr_valid;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_pc;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0103)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken),
    .instr_valid(instr_valid), .pc(pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_fields(input string tag, input logic [31:0] word);
    check({tag, ".opcode"}, 32'(opcode), 32'(word[31:26]));
    check({tag, ".rs"},     32'(rs),     32'(word[25:21]));
    check({tag, ".rt"},     32'(rt),     32'(word[20:16]));
    check({tag, ".rd"},     32'(rd),     32'(word[15:11]));
    check({tag, ".funct"},  32'(funct),  32'(word[5:0]));
    check({tag, ".imm"},    32'(imm),    32'(word[15:0]));
  endtask

  // Entered at a negedge where the DUT should be requesting model_pc.
  // Leaves at the negedge after the execute window is released.
  task automatic fetch_one(input logic [31:0] word, input int waits, input int stalls, input logic bt);
    logic [31:0] offs;
    check("req_start", 32'(imem_req), 32'd1);
    check("addr_start", imem_addr, model_pc);
    check("valid_in_req", 32'(instr_valid), 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, model_pc);
      check("valid_wait", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_exec", 32'(instr_valid), 32'd1);
    check("req_exec", 32'(imem_req), 32'd0);
    check("pc_exec", pc, model_pc);
    check_fields("exec", word);
    for (int i = 0; i < stalls; i++) begin
      stall        = 1'b1;
      branch_taken = 1'($urandom_range(0, 1));
      imem_ack     = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      @(negedge clk);
      check("valid_stall", 32'(instr_valid), 32'd1);
      check("req_stall", 32'(imem_req), 32'd0);
      check("pc_stall", pc, model_pc);
      check_fields("stall", word);
    end
    stall        = 1'b0;
    imem_ack     = 1'b0;
    branch_taken = bt;
    offs     = bt ? {{14{word[15]}}, word[15:0], 2'b00} : 32'd0;
    model_pc = model_pc + 32'd4 + offs;
    @(negedge clk);
    branch_taken = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    model_pc = 32'h100;
    check("boot_req", 32'(imem_req), 32'd0);
    check("boot_valid", 32'(instr_valid), 32'd0);
    check("boot_pc", pc, 32'h100);
    check("boot_ir", 32'(opcode), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;

    fetch_one(32'h0109_5020, 0, 0, 1'b0);              // add $10,$8,$9 @0x100
    check("add_rs", 32'(rs), 32'd8);
    fetch_one($urandom, 3, 0, 1'b0);                    // wait states @0x104
    fetch_one({6'h04, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1); // 0x108 -> 0x104
    check("beq_back", model_pc, 32'h104);
    fetch_one($urandom, 1, 0, 1'b0);
    fetch_one({6'h04, 5'd3, 5'd4, 16'h0003}, 0, 0, 1'b1); // 0x108 -> 0x118
    fetch_one({6'h04, 5'd3, 5'd4, 16'hFFFB}, 0, 0, 1'b1); // 0x118 -> 0x108
    fetch_one({6'h04, 5'd3, 5'd4, 16'h0003}, 0, 0, 1'b0); // 0x108 -> 0x10C
    fetch_one({6'h04, 5'd5, 5'd6, 16'hFFBB}, 0, 5, 1'b1); // 0x10C -> 0xFFFFFFFC
    check("wrap_lo", model_pc, 32'hFFFF_FFFC);
    fetch_one($urandom, 0, 0, 1'b0);                    // top wraps to 0
    check("wrap_hi", imem_addr, 32'h0);

    for (int n = 0; n < 40; n++)
      fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Reset while requesting, with ack in the same cycle: data must be dropped.
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_ir", 32'(imm), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_ir", 32'(opcode), 32'd0);
    model_pc = 32'h100;
    fetch_one($urandom, 1, 1, 1'($urandom_range(0, 1)));
    fetch_one($urandom, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder in the single-cycle MIPS-subset core (R-type, ADDI, BEQ).
- Holds the PC and requests 32-bit instruction words from instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register and presents the decoded fields (opcode, funct, rs, rt, rd, imm) to the decoder and register file for one execute window.
- Computes the next PC from the decoder's branch decision.

Parameters:
ADDR_W, 32, width of PC and instruction-memory byte address
RESET_PC, 0, PC value loaded on reset; bits [1:0] are ignored and forced to 0

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  byte address of requested word, equals pc
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  instruction word, sampled only when imem_req && imem_ack
stall  input  1  downstream hold; freezes the execute window
branch_taken  input  1  decoder branch select (BEQ && zero), sampled in EXEC
instr_valid  output  1  instruction fields valid for execution this cycle
pc  output  ADDR_W  address of the instruction being fetched or executed
opcode  output  6  IR[31:26]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
funct  output  6  IR[5:0]
imm  output  16  IR[15:0]

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - state=BOOT, pc={RESET_PC[ADDR_W-1:2],2'b00}, IR=32'h0.
  - imem_req=0, instr_valid=0.
  - Reset mid-fetch abandons the request; a late ack after reset is ignored.
- States:
  - BOOT: one cycle, no request, always goes to REQ. Gives memory one idle cycle after reset.
  - REQ: imem_req=1, imem_addr=pc. Stay while imem_ack=0, with imem_addr stable. On imem_req && imem_ack: IR<=imem_rdata, go to EXEC. Zero-wait memory (ack in the first REQ cycle) is legal.
  - EXEC: imem_req=0, instr_valid=1, fields driven from IR.
    - stall=1: stay in EXEC; IR and pc unchanged; branch_taken ignored.
    - stall=0: update pc, go to REQ.
- Next-PC arithmetic, evaluated in EXEC only:
  - seq = pc + 4.
  - branch_taken=0: pc <= seq.
  - branch_taken=1: pc <= seq + ({{(ADDR_W-18){imm[15]}},imm,2'b00}).
  - Arithmetic is modulo 2^ADDR_W; wrap-around at top and bottom of the address space is silent.
  - pc[1:0] is always 00.
- Latency:
  - Minimum 2 cycles per instruction: REQ with ack, then EXEC.
  - Each memory wait cycle and each stall cycle adds 1.
- Memory handshake:
  - imem_ack while imem_req=0 is ignored; IR is not written.
  - imem_rdata is don't-care without ack.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Field outputs reflect IR at all times. Downstream logic must qualify them with instr_valid.
- branch_taken and stall both high in the same EXEC cycle: stall wins, branch_taken is resampled on the release cycle.

Test Plan:
- Reset release, RESET_PC=32'h0000_0103, ack tied high -> imem_req=0 in cycle 1 (BOOT); imem_req=1 with imem_addr=32'h100 in cycle 2; instr_valid=1 in cycle 3.
- Straight-line sequence, zero-wait memory returning 32'h0109_5020 (add $10,$8,$9) at 0x100 -> EXEC shows opcode=0, rs=8, rt=9, rd=10, funct=6'h20; next request at 0x104; instr_valid toggles 0/1 every cycle.
- Wait states, ack delayed 3 cycles at 0x104 -> imem_req and imem_addr=0x104 held for 4 cycles; IR unchanged until the ack cycle; EXEC follows.
- BEQ at 0x108, imm=16'hFFFE, branch_taken=1 -> next imem_addr=0x108+4-8=0x104. Repeat with imm=16'h0003 -> 0x118. Repeat with branch_taken=0 -> 0x10C.
- Stall 5 cycles in EXEC while branch_taken toggles -> instr_valid stays 1, pc and fields frozen; only branch_taken on the release cycle decides the next PC.
- Reset asserted in REQ with ack arriving the same cycle -> IR=0, state BOOT, imem_req=0 next cycle. Separately: pc=32'hFFFF_FFFC sequential -> wraps to 0x0.
